sd_spi_master: RTL
==================

# sd_spi_master

Parametrised SPI master engine for the SD-card path, replacing the fixed-divider, 8-bit, single-select SPI master used by the SD controller. It accepts one word per command over a valid/ready handshake, drives SPI mode 0 (CPOL=0, CPHA=0) on one of NUM_CS selects, and returns the received word. Run-time divider, chip-select hold and a dummy-clock mode cover SD initialisation (slow clock with CS high) and fast block transfer without re-synthesis.

## Interface
- DATA_W, 8, bits per transfer, ≥2
- NUM_CS, 1, number of chip-select lines, ≥1
- DIV_W, 8, width of run-time divider
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- clk_div  in  DIV_W  SCK half-period = clk_div+1 clk cycles; sampled at command accept
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle, can accept
- cmd_data  in  DATA_W  word to send, MSB first
- cmd_cs_idx  in  max(1,$clog2(NUM_CS))  select index
- cmd_hold  in  1  keep CS asserted after this word
- cmd_dummy  in  1  clock word with all CS deasserted
- rsp_valid  out  1  one-cycle pulse, transfer done
- rsp_data  out  DATA_W  received word, held until next rsp_valid
- busy  out  1  transfer in progress
- spi_sck  out  1  serial clock
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- spi_cs_n  out  NUM_CS  active-low selects

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE: cmd_ready=1, busy=0. Accept on cmd_valid && cmd_ready: latch cmd_data into shift register, latch clk_div, cs_idx, hold, dummy; go LOW with bit counter = DATA_W.
- Accept: if dummy=1 or cs_idx ≥ NUM_CS, all spi_cs_n=1 and spi_mosi=1 for the whole word; otherwise only spi_cs_n[cs_idx]=0 (any other held select released in the same cycle).
- LOW: spi_sck=0, spi_mosi=current MSB; after clk_div+1 cycles go HIGH.
- HIGH entry edge: shift spi_miso into receive register LSB. spi_sck=1 for clk_div+1 cycles. Then, if bit counter=1, go DONE; else decrement, shift transmit register left, go LOW.
- DONE (one cycle): spi_sck=0, rsp_valid=1, rsp_data=received word; spi_cs_n released unless hold=1 and not dummy. Next state IDLE.
- Held CS stays asserted through IDLE until the next accepted command with hold=0 completes, selects another index, or is dummy.
- spi_mosi=1 whenever no word is shifting.
- No response backpressure: rsp_valid is a pulse.

## Timing
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, spi_sck=0, spi_mosi=1, spi_cs_n=all 1, state IDLE.
- Accept at edge E0: from E0 CS low and MSB on spi_mosi; first SCK rise at E0+(clk_div+1).
- rsp_valid high in the cycle beginning E0+2·DATA_W·(clk_div+1); cmd_ready high one cycle later.
- Back-to-back command interval: 2·DATA_W·(clk_div+1)+2 cycles.
- clk_div changes mid-word are ignored. clk_div=0 gives SCK=clk/2.
- Reset mid-transfer: immediate return to reset values, no rsp_valid, held CS dropped.

## Structure
- Package sd_spi_pkg: state enum, CS index width function, default parameter constants.
- Sub-module sd_spi_clkgen: half-period down-counter loaded with clk_div, emits rise/fall strobes and spi_sck; the FSM, shifters and CS logic stay in the top.

## Test plan
- DATA_W=8, clk_div=1, send 0xA5, slave returns 0x3C -> MOSI bits 10100101, rsp_data=0x3C, rsp_valid exactly 32 cycles after accept, CS low for the 32 cycles then high.
- Dummy mode, clk_div=124, 10 words of 0xFF -> 80 SCK pulses, spi_cs_n all 1, spi_mosi constant 1.
- NUM_CS=2, hold=1 on cs 1 for 3 words then hold=0 -> spi_cs_n[1] continuously low across all 4 words, high after the last DONE; spi_cs_n[0] never low.
- Held cs 0 then command on cs 1 -> spi_cs_n[0] rises and spi_cs_n[1] falls on the same edge.
- clk_div=0 vs clk_div=3, DATA_W=16 -> rsp_valid latency 32 and 128 cycles; clk_div toggled mid-word has no effect.
- Reset asserted mid-word -> next edge sck=0, mosi=1, cs_n all 1, no rsp_valid; a following command completes normally.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI master.
//   state_t   : transfer FSM states
//   cs_idx_w  : width of a chip-select index for a given number of selects
//   DEF_*     : default parameter values
package sd_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CS = 1;
    localparam int DEF_DIV_W  = 8;

    function automatic int cs_idx_w(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/sd_spi_clkgen.sv
// SCK generator for the SD SPI master.
// A half-period down-counter reloaded with the divider captured at load;
// each terminal count toggles SCK and raises the rise or fall strobe.
//   clk, reset : system clock, async active-high reset
//   load       : command accepted; capture div, restart with SCK low
//   div        : half-period minus one, in clk cycles
//   run        : a word is shifting; when low SCK is forced low
//   sck        : serial clock
//   rise, fall : one-cycle strobes, asserted in the cycle before SCK toggles
module sd_spi_clkgen
    import sd_spi_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    output logic             sck,
    output logic             rise,
    output logic             fall
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             sck_q;
    logic             tc;

    assign tc   = run && (cnt_q == '0);
    assign rise = tc && !sck_q;
    assign fall = tc && sck_q;
    assign sck  = sck_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            div_q <= '0;
            sck_q <= 1'b0;
        end else if (load) begin
            cnt_q <= div;
            div_q <= div;
            sck_q <= 1'b0;
        end else if (run) begin
            if (tc) begin
                cnt_q <= div_q;
                sck_q <= !sck_q;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end else begin
            sck_q <= 1'b0;
        end
    end

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 master engine for the SD-card path.
// One word per command over valid/ready; received word returned with a
// one-cycle rsp_valid pulse. Divider, CS hold and dummy clocking are
// selected per command.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | ready for a command; a held CS stays asserted
//   LOW   | SCK low half-period, MSB of tx word on MOSI
//   HIGH  | SCK high half-period, MISO sampled on entry
//   DONE  | one cycle, rsp_valid, CS released unless held
//
// Ports: clk, reset (async active-high), clk_div, cmd_valid/cmd_ready,
// cmd_data, cmd_cs_idx, cmd_hold, cmd_dummy, rsp_valid, rsp_data, busy,
// spi_sck, spi_mosi, spi_miso, spi_cs_n (active-low, one per device).
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CS = DEF_NUM_CS,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DIV_W-1:0]            clk_div,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [DATA_W-1:0]           cmd_data,
    input  logic [cs_idx_w(NUM_CS)-1:0] cmd_cs_idx,
    input  logic                        cmd_hold,
    input  logic                        cmd_dummy,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        busy,
    output logic                        spi_sck,
    output logic                        spi_mosi,
    input  logic                        spi_miso,
    output logic [NUM_CS-1:0]           spi_cs_n
);

    localparam int BCW = $clog2(DATA_W + 1);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rsp_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic              hold_q;
    logic              desel_q;
    logic [NUM_CS-1:0] cs_n_q;
    logic [NUM_CS-1:0] sel_n;
    logic              accept;
    logic              run;
    logic              desel;
    logic              last_bit;
    logic              sck_rise;
    logic              sck_fall;

    assign accept   = (state_q == ST_IDLE) && cmd_valid;
    assign run      = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign last_bit = (bit_cnt_q == BCW'(1));

    // Out-of-range index behaves like a dummy word: nothing selected.
    assign desel = cmd_dummy || (int'(cmd_cs_idx) >= NUM_CS);

    always_comb begin
        sel_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (!desel && (int'(cmd_cs_idx) == i)) begin
                sel_n[i] = 1'b0;
            end
        end
    end

    sd_spi_clkgen #(
        .DIV_W(DIV_W)
    ) u_clkgen (
        .clk  (clk),
        .reset(reset),
        .load (accept),
        .div  (clk_div),
        .run  (run),
        .sck  (spi_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_LOW;
            ST_LOW:  if (sck_rise) state_d = ST_HIGH;
            ST_HIGH: if (sck_fall) state_d = last_bit ? ST_DONE : ST_LOW;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q      <= '0;
            rx_q      <= '0;
            rsp_q     <= '0;
            bit_cnt_q <= '0;
            hold_q    <= 1'b0;
            desel_q   <= 1'b1;
            cs_n_q    <= '1;
        end else begin
            // Loading sel_n on accept also drops a select held for another index.
            if (accept) begin
                tx_q      <= cmd_data;
                bit_cnt_q <= BCW'(DATA_W);
                hold_q    <= cmd_hold;
                desel_q   <= desel;
                cs_n_q    <= sel_n;
            end
            if ((state_q == ST_LOW) && sck_rise) begin
                rx_q <= {rx_q[DATA_W-2:0], spi_miso};
            end
            if ((state_q == ST_HIGH) && sck_fall) begin
                if (last_bit) begin
                    rsp_q <= rx_q;
                    if (!(hold_q && !desel_q)) begin
                        cs_n_q <= '1;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q - BCW'(1);
                    tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_data  = rsp_q;
    assign spi_mosi  = (run && !desel_q) ? tx_q[DATA_W-1] : 1'b1;
    assign spi_cs_n  = cs_n_q;

endmodule
